// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-cycle event strobes into fixed-length high windows
// separated by a guaranteed low gap, with a one-deep event queue and drop flag.
module pulse_stretch #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter bit RETRIG      = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse_in,
    output logic       level_out,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] acc_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       acc_q, acc_d;
    logic             retrigHit;

    assign retrigHit = RETRIG && pulse_in && (state_q == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
            acc_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
        end
    end

    // A pulse arriving while a queued event is consumed re-queues itself, so the
    // exit paths keep pend set only when both were present and never flag a drop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        overflow_d = 1'b0;
        acc_d      = acc_q;
        unique case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_RELOAD;
                    acc_d   = acc_q + 8'd1;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (retrigHit) begin
                    cnt_d = HOLD_RELOAD;
                end else if (pulse_in) begin
                    if (!pend_q) pend_d = 1'b1;
                    else         overflow_d = 1'b1;
                end
                if ((cnt_q == '0) && !retrigHit) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_RELOAD;
                    end else if (pend_q || pulse_in) begin
                        state_d    = HOLD;
                        cnt_d      = HOLD_RELOAD;
                        pend_d     = pend_q && pulse_in;
                        overflow_d = 1'b0;
                        acc_d      = acc_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q - 1'b1;
                if (pulse_in) begin
                    if (!pend_q) pend_d = 1'b1;
                    else         overflow_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (pend_q || pulse_in) begin
                        state_d    = HOLD;
                        cnt_d      = HOLD_RELOAD;
                        pend_d     = pend_q && pulse_in;
                        overflow_d = 1'b0;
                        acc_d      = acc_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign level_out = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign acc_cnt   = acc_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: default, retrigger and no-gap variants
// share clock, reset and strobe; each test checks the variant it targets.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pulseIn = 1'b0;
    logic       levelA, busyA, ovfA;
    logic [7:0] accA;
    logic       levelR, busyR, ovfR;
    logic [7:0] accR;
    logic       levelG, busyG, ovfG;
    logic [7:0] accG;
    int         total = 0;
    int         bad = 0;

    pulse_stretch #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIG(1'b0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .pulse_in(pulseIn),
        .level_out(levelA), .busy(busyA), .overflow(ovfA), .acc_cnt(accA));

    pulse_stretch #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIG(1'b1), .CNT_W(8)) dutRetrig (
        .clk(clk), .reset(reset), .pulse_in(pulseIn),
        .level_out(levelR), .busy(busyR), .overflow(ovfR), .acc_cnt(accR));

    pulse_stretch #(.HOLD_CYCLES(8), .GAP_CYCLES(0), .RETRIG(1'b0), .CNT_W(8)) dutNoGap (
        .clk(clk), .reset(reset), .pulse_in(pulseIn),
        .level_out(levelG), .busy(busyG), .overflow(ovfG), .acc_cnt(accG));

    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after an edge with reset released, so the
    // next posedge is edge 0 of the following test.
    task automatic doReset();
        pulseIn = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        pulseIn = 1'b0;
        reset   = 1'b0;
        #2;
        total++;
        if ({levelA, busyA, ovfA, accA} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL reset_hold got=%b/%b/%b/%0d want=0/0/0/0", levelA, busyA, ovfA, accA);
        end
        total++;
        if ({levelR, busyR, levelG, busyG, accR, accG} !== 20'd0) begin
            bad++;
            $display("[TB] FAIL reset_variants got lvl=%b%b busy=%b%b acc=%0d/%0d want all 0",
                     levelR, levelG, busyR, busyG, accR, accG);
        end
        doReset();
        @(posedge clk); #1;
        total++;
        if ({levelA, busyA, ovfA, accA} !== 11'd0) begin
            bad++;
            $display("[TB] FAIL reset_idle got=%b/%b/%b/%0d want=0/0/0/0", levelA, busyA, ovfA, accA);
        end
    endtask

    task automatic test_single();
        doReset();
        for (int c = 0; c <= 12; c++) begin
            pulseIn = (c == 0);
            @(posedge clk); #1;
            total++;
            if (levelA !== ((c + 1) >= 1 && (c + 1) <= 8)) begin
                bad++;
                $display("[TB] FAIL single_level cycle=%0d got=%b want=%b", c + 1, levelA, !levelA);
            end
            total++;
            if (busyA !== ((c + 1) <= 10)) begin
                bad++;
                $display("[TB] FAIL single_busy cycle=%0d got=%b want=%b", c + 1, busyA, !busyA);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accA !== 8'd1) begin
            bad++;
            $display("[TB] FAIL single_acc got=%0d want=1", accA);
        end
    endtask

    // Pulses at 0 and 3 queue one event; optional third pulse at 4 is dropped.
    task automatic test_queue(input bit withDrop);
        int cyc;
        bit expLevel;
        doReset();
        for (int c = 0; c <= 22; c++) begin
            pulseIn = (c == 0) || (c == 3) || (withDrop && c == 4);
            @(posedge clk); #1;
            cyc = c + 1;
            expLevel = (cyc >= 1 && cyc <= 8) || (cyc >= 11 && cyc <= 18);
            total++;
            if (levelA !== expLevel) begin
                bad++;
                $display("[TB] FAIL queue_level drop=%0d cycle=%0d got=%b want=%b", withDrop, cyc, levelA, expLevel);
            end
            total++;
            if (busyA !== (cyc <= 20)) begin
                bad++;
                $display("[TB] FAIL queue_busy drop=%0d cycle=%0d got=%b want=%b", withDrop, cyc, busyA, cyc <= 20);
            end
            total++;
            if (ovfA !== (withDrop && cyc == 5)) begin
                bad++;
                $display("[TB] FAIL queue_overflow drop=%0d cycle=%0d got=%b want=%b", withDrop, cyc, ovfA, withDrop && cyc == 5);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accA !== 8'd2) begin
            bad++;
            $display("[TB] FAIL queue_acc drop=%0d got=%0d want=2", withDrop, accA);
        end
    endtask

    // Pulse at edge 10 lands exactly when the queued event is consumed.
    task automatic test_requeue();
        int cyc;
        bit expLevel;
        doReset();
        for (int c = 0; c <= 32; c++) begin
            pulseIn = (c == 0) || (c == 3) || (c == 10);
            @(posedge clk); #1;
            cyc = c + 1;
            expLevel = (cyc <= 8) || (cyc >= 11 && cyc <= 18) || (cyc >= 21 && cyc <= 28);
            total++;
            if (levelA !== expLevel) begin
                bad++;
                $display("[TB] FAIL requeue_level cycle=%0d got=%b want=%b", cyc, levelA, expLevel);
            end
            total++;
            if (ovfA !== 1'b0) begin
                bad++;
                $display("[TB] FAIL requeue_overflow cycle=%0d got=%b want=0", cyc, ovfA);
            end
            total++;
            if (busyA !== (cyc <= 30)) begin
                bad++;
                $display("[TB] FAIL requeue_busy cycle=%0d got=%b want=%b", cyc, busyA, cyc <= 30);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accA !== 8'd3) begin
            bad++;
            $display("[TB] FAIL requeue_acc got=%0d want=3", accA);
        end
    endtask

    task automatic test_retrig();
        int cyc;
        doReset();
        for (int c = 0; c <= 16; c++) begin
            pulseIn = (c == 0) || (c == 5);
            @(posedge clk); #1;
            cyc = c + 1;
            total++;
            if (levelR !== (cyc <= 13)) begin
                bad++;
                $display("[TB] FAIL retrig_level cycle=%0d got=%b want=%b", cyc, levelR, cyc <= 13);
            end
            total++;
            if (busyR !== (cyc <= 15)) begin
                bad++;
                $display("[TB] FAIL retrig_busy cycle=%0d got=%b want=%b", cyc, busyR, cyc <= 15);
            end
            total++;
            if (ovfR !== 1'b0) begin
                bad++;
                $display("[TB] FAIL retrig_overflow cycle=%0d got=%b want=0", cyc, ovfR);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accR !== 8'd1) begin
            bad++;
            $display("[TB] FAIL retrig_acc got=%0d want=1", accR);
        end
    endtask

    task automatic test_no_gap();
        int cyc;
        doReset();
        for (int c = 0; c <= 18; c++) begin
            pulseIn = (c == 0) || (c == 8);
            @(posedge clk); #1;
            cyc = c + 1;
            total++;
            if (levelG !== (cyc <= 16)) begin
                bad++;
                $display("[TB] FAIL nogap_level cycle=%0d got=%b want=%b", cyc, levelG, cyc <= 16);
            end
            total++;
            if (busyG !== (cyc <= 16)) begin
                bad++;
                $display("[TB] FAIL nogap_busy cycle=%0d got=%b want=%b", cyc, busyG, cyc <= 16);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accG !== 8'd2) begin
            bad++;
            $display("[TB] FAIL nogap_acc got=%0d want=2", accG);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        for (int c = 0; c <= 3; c++) begin
            pulseIn = (c == 0);
            @(posedge clk); #1;
        end
        pulseIn = 1'b0;
        total++;
        if ({levelA, busyA, accA} !== {2'b11, 8'd1}) begin
            bad++;
            $display("[TB] FAIL areset_before got=%b/%b/%0d want=1/1/1", levelA, busyA, accA);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({levelA, busyA, accA} !== 10'd0) begin
            bad++;
            $display("[TB] FAIL areset_immediate got=%b/%b/%0d want=0/0/0", levelA, busyA, accA);
        end
        #1;
        reset = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            pulseIn = (c == 0);
            @(posedge clk); #1;
            total++;
            if (levelA !== ((c + 1) <= 8)) begin
                bad++;
                $display("[TB] FAIL areset_window cycle=%0d got=%b want=%b", c + 1, levelA, (c + 1) <= 8);
            end
        end
        pulseIn = 1'b0;
        total++;
        if (accA !== 8'd1) begin
            bad++;
            $display("[TB] FAIL areset_acc got=%0d want=1", accA);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue(1'b0);
        test_queue(1'b1);
        test_requeue();
        test_retrig();
        test_no_gap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
